axi_lsu_master: RTL
===================

AXI_LSU_MASTER -- requirements
Module: axi_lsu_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, giving response-watchdog limit in ACLK cycles (used only with AXI_MASTER_TIMEOUT_EN).
REQ-002 SHALL have ports ACLK (in, 1, sole clock) and ARESETn (in, 1, asynchronous active-low reset).
REQ-003 SHALL have req_valid (in, 1): core load/store request.
REQ-004 SHALL have req_ready (out, 1): request accepted this cycle.
REQ-005 SHALL have req_we (in, 1), req_addr (in, AXI_ADDR_BITS), req_wdata (in, AXI_DATA_BITS) and req_wstrb (in, AXI_DATA_BITS/8): write flag, address, write data, byte strobe.
REQ-006 SHALL have rsp_valid (out, 1), rsp_rdata (out, AXI_DATA_BITS) and rsp_err (out, 1): completion pulse, load data, error flag.
REQ-007 SHALL have ARADDR (out, AXI_ADDR_BITS), ARVALID (out, 1) and ARREADY (in, 1): AXI read-address channel.
REQ-008 SHALL have RDATA (in, AXI_DATA_BITS), RRESP (in, 2), RVALID (in, 1) and RREADY (out, 1): AXI read-data channel.
REQ-009 SHALL have AWADDR (out, AXI_ADDR_BITS), AWVALID (out, 1) and AWREADY (in, 1): AXI write-address channel.
REQ-010 SHALL have WDATA (out, AXI_DATA_BITS), WSTRB (out, AXI_DATA_BITS/8), WVALID (out, 1) and WREADY (in, 1): AXI write-data channel.
REQ-011 SHALL have BRESP (in, 2), BVALID (in, 1) and BREADY (out, 1): AXI write-response channel.

Function
REQ-012 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE, with at most one transaction outstanding.
REQ-013 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready, SHALL register address, data and strobe, then go to RD_ADDR (req_we=0) or WR_REQ (req_we=1).
REQ-014 SHALL drive all AXI outputs from registers: ARVALID rises the cycle after acceptance, holds with stable ARADDR until ARREADY, then goes to RD_DATA.
REQ-015 SHALL assert RREADY only in RD_DATA; on RVALID it SHALL capture RDATA, set err=(RRESP!=AXI_RESP_OKAY), and go to DONE.
REQ-016 SHALL raise AWVALID and WVALID together in WR_REQ; each SHALL drop independently on its own handshake, and WR_RESP SHALL be entered once both have completed, in either order or in the same cycle.
REQ-017 SHALL assert BREADY only in WR_RESP; on BVALID it SHALL set err=(BRESP!=AXI_RESP_OKAY) and go to DONE.
REQ-018 SHALL pulse rsp_valid for exactly one cycle in DONE, with rsp_rdata=captured data for reads, 0 for writes, plus rsp_err; the FSM SHALL return to IDLE next cycle with no backpressure.
REQ-019 SHALL give a minimum load latency, acceptance edge to rsp_valid, of 3 cycles when ARREADY=1 and RVALID arrives the first RD_DATA cycle.
REQ-020 SHALL never assert ARVALID concurrently with AWVALID or WVALID.
REQ-021 SHALL ignore RVALID and BVALID received outside RD_DATA and WR_RESP respectively.

Reset
REQ-022 SHALL, on ARESETn low, immediately (asynchronously) force state=IDLE; all VALID/READY outputs, rsp_valid and rsp_err to 0; all address, data and strobe outputs to 0; with any in-flight transaction dropped.

Configuration
REQ-023 SHALL, with AXI_MASTER_TIMEOUT_EN defined, count cycles spent in RD_ADDR/RD_DATA/WR_REQ/WR_RESP, and at TIMEOUT_CYCLES deassert all valids, go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-024 SHALL, without AXI_MASTER_TIMEOUT_EN, contain no counter and wait indefinitely.

Structure
REQ-025 SHALL take AXI_ADDR_BITS, AXI_DATA_BITS, AXI_RESP_OKAY and the FSM state enum typedef from package defs.
REQ-026 SHALL be a single module with no sub-modules; the watchdog SHALL be an inline counter.

Verification
REQ-027 SHALL check: load addr 0x0000_0010, ARREADY=1, RDATA=0xDEAD_BEEF/OKAY next cycle -> rsp_valid at +3 cycles, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-028 SHALL check: store addr 0x20, wdata 0x1234_5678, wstrb 0x3, AWREADY delayed 2 cycles after WREADY -> both handshakes occur, BREADY follows, rsp_valid once, err=0.
REQ-029 SHALL check: load with RRESP=2'b10 -> rsp_err=1, rsp_rdata=0xDEAD_BEEF.
REQ-030 SHALL check: ARREADY=0 for 10 cycles -> ARADDR/ARVALID stable throughout, req_ready=0.
REQ-031 SHALL check: ARESETn pulsed low in WR_RESP -> outputs zero immediately, next req_valid accepted in IDLE.
REQ-032 SHALL check: with AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, no BVALID -> rsp_valid with rsp_err=1 after 8 cycles.

Source files
------------

// File: rtl/axi_lsu_master_pkg.sv
// Shared widths, response encoding, FSM state type and latched-request record for the AXI LSU master.
package defs;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } lsu_state_e;

    typedef struct packed {
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_DATA_BITS-1:0] wdata;
        logic [AXI_STRB_BITS-1:0] wstrb;
    } lsu_req_t;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lsu_master.sv
// Single-outstanding core load/store to AXI master; optional watchdog under AXI_MASTER_TIMEOUT_EN.
// Best-case load: rsp_valid in the 3rd cycle after acceptance. req_ready only in IDLE; rsp has no backpressure.
module axi_lsu_master
    import defs::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AXI_ADDR_BITS-1:0] req_addr,
    input  logic [AXI_DATA_BITS-1:0] req_wdata,
    input  logic [AXI_STRB_BITS-1:0] req_wstrb,

    output logic                     rsp_valid,
    output logic [AXI_DATA_BITS-1:0] rsp_rdata,
    output logic                     rsp_err,

    output logic [AXI_ADDR_BITS-1:0] ARADDR,
    output logic                     ARVALID,
    input  logic                     ARREADY,

    input  logic [AXI_DATA_BITS-1:0] RDATA,
    input  logic [1:0]               RRESP,
    input  logic                     RVALID,
    output logic                     RREADY,

    output logic [AXI_ADDR_BITS-1:0] AWADDR,
    output logic                     AWVALID,
    input  logic                     AWREADY,

    output logic [AXI_DATA_BITS-1:0] WDATA,
    output logic [AXI_STRB_BITS-1:0] WSTRB,
    output logic                     WVALID,
    input  logic                     WREADY,

    input  logic [1:0]               BRESP,
    input  logic                     BVALID,
    output logic                     BREADY
);

    lsu_state_e state_q, state_d;

    lsu_req_t                 req_q, req_d;
    logic                     req_ready_q, req_ready_d;
    logic                     arvalid_q, arvalid_d;
    logic                     rready_q, rready_d;
    logic                     awvalid_q, awvalid_d;
    logic                     wvalid_q, wvalid_d;
    logic                     bready_q, bready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;

    logic req_fire;
    logic r_fire;
    logic b_fire;
    logic tmo_fire;

    assign req_fire = req_valid && req_ready_q;
    assign r_fire   = rready_q && RVALID;
    assign b_fire   = bready_q && BVALID;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             busy;

    assign busy = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                  (state_q == WR_REQ)  || (state_q == WR_RESP);

    // A handshake landing on the final watchdog cycle still completes normally.
    assign tmo_fire = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) && !r_fire && !b_fire;

    always_comb begin
        tmo_cnt_d = '0;
        if (busy && !tmo_fire) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_param;

    assign tmo_fire             = 1'b0;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    state_d = req_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && ARREADY) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_fire) begin
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // Address and data may complete in either order or together.
                if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (tmo_fire) begin
            state_d = DONE;
        end
    end

    always_comb begin
        req_ready_d = (state_d == IDLE);
        arvalid_d   = (state_d == RD_ADDR);
        rready_d    = (state_d == RD_DATA);
        bready_d    = (state_d == WR_RESP);

        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_d == WR_REQ) begin
            awvalid_d = (state_q == IDLE) || (awvalid_q && !AWREADY);
            wvalid_d  = (state_q == IDLE) || (wvalid_q && !WREADY);
        end

        req_d = req_q;
        if (req_fire) begin
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.wstrb = req_wstrb;
        end

        rsp_valid_d = (state_d == DONE);
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (tmo_fire) begin
            rsp_err_d = 1'b1;
        end else if (r_fire) begin
            rsp_rdata_d = RDATA;
            rsp_err_d   = resp_is_err(RRESP);
        end else if (b_fire) begin
            rsp_err_d = resp_is_err(BRESP);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            req_q       <= '0;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign ARADDR  = req_q.addr;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;
    assign AWADDR  = req_q.addr;
    assign AWVALID = awvalid_q;
    assign WDATA   = req_q.wdata;
    assign WSTRB   = req_q.wstrb;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;

endmodule
